ddr_frame_reader: RTL and testbench

//  Read-back counterpart of the camera DDR write path. On a controller start it reads one stored frame from
//  DDR (odd/even buffer) as AXI4 read bursts, packs 16x32-bit beats into 512-bit words and emits Ethernet-

---
 rtl/ddr_frame_reader.sv | 215 +++++++++++++++++++++
 tb/tb_ddr_frame_reader.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_frame_reader.sv
// ddr_frame_reader
// Reads one stored camera frame back out of DDR as 16-beat AXI4 read bursts,
// packs each burst into a 512-bit word and emits Ethernet-framed packets
// (header word plus PKT_WORDS payload words) on the 520-bit packet bus.
module ddr_frame_reader #(
    parameter logic [31:0] BUF0_BASE    = 32'h2BC0_0000,
    parameter logic [31:0] BUF1_BASE    = 32'h2BE0_0000,
    parameter int          FRAME_BURSTS = 9600,
    parameter int          PKT_WORDS    = 16,
    parameter logic [47:0] DST_MAC      = 48'hADAD_ADAD_ADAD,
    parameter logic [47:0] SRC_MAC      = 48'hACAC_ACAC_ACAC,
    parameter logic [15:0] ETH_TYPE     = 16'h9000
) (
    input  logic         clk,
    input  logic         aresetn,
    input  logic         ddr_read_start,
    input  logic         ddr_read_start_valid,
    output logic         ddr_read_start_ready,
    input  logic         odd_even_flag,
    output logic         ddr_read_finish,
    output logic         ddr_read_finish_valid,
    input  logic         ddr_read_finish_ready,
    output logic         frame_error,
    output logic [519:0] pkt_out_data,
    output logic         pkt_out_en,
    output logic [255:0] pkt_out_md,
    output logic         pkt_out_md_en,
    input  logic         pkt_out_alf,
    output logic         M_AXI_ARID,
    output logic [31:0]  M_AXI_ARADDR,
    output logic [7:0]   M_AXI_ARLEN,
    output logic [2:0]   M_AXI_ARSIZE,
    output logic [1:0]   M_AXI_ARBURST,
    output logic         M_AXI_ARLOCK,
    output logic [3:0]   M_AXI_ARCACHE,
    output logic [2:0]   M_AXI_ARPROT,
    output logic [3:0]   M_AXI_ARQOS,
    output logic         M_AXI_ARUSER,
    output logic         M_AXI_ARVALID,
    input  logic         M_AXI_ARREADY,
    input  logic         M_AXI_RID,
    input  logic [31:0]  M_AXI_RDATA,
    input  logic [1:0]   M_AXI_RRESP,
    input  logic         M_AXI_RLAST,
    input  logic         M_AXI_RUSER,
    input  logic         M_AXI_RVALID,
    output logic         M_AXI_RREADY
);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_AR, S_RD, S_WORD, S_FIN} state_t;

    localparam logic [13:0] LAST_BURST = 14'(FRAME_BURSTS - 1);
    localparam logic [15:0] LAST_WORD  = 16'(PKT_WORDS - 1);
    localparam logic [15:0] PKT_LEN    = 16'(PKT_WORDS + 1);

    state_t         state_q, state_d;
    logic [31:0]    base_q, base_d;
    logic           flag_q, flag_d;
    logic [13:0]    burst_cnt_q, burst_cnt_d;
    logic [15:0]    pkt_idx_q, pkt_idx_d;
    logic [15:0]    word_idx_q, word_idx_d;
    logic [4:0]     beat_q, beat_d;
    logic [511:0]   word_q, word_d;
    logic           frame_error_q, frame_error_d;

    logic           last_word;
    logic           unused_inputs;

    assign last_word     = (word_idx_q == LAST_WORD);
    assign unused_inputs = ^{M_AXI_RID, M_AXI_RUSER};

    // State and datapath registers; reset drops any burst in flight.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= S_IDLE;
            base_q        <= '0;
            flag_q        <= 1'b0;
            burst_cnt_q   <= '0;
            pkt_idx_q     <= '0;
            word_idx_q    <= '0;
            beat_q        <= '0;
            word_q        <= '0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            flag_q        <= flag_d;
            burst_cnt_q   <= burst_cnt_d;
            pkt_idx_q     <= pkt_idx_d;
            word_idx_q    <= word_idx_d;
            beat_q        <= beat_d;
            word_q        <= word_d;
            frame_error_q <= frame_error_d;
        end
    end

    // Next-state logic: frame sequencing, beat packing and error tracking.
    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        flag_d        = flag_q;
        burst_cnt_d   = burst_cnt_q;
        pkt_idx_d     = pkt_idx_q;
        word_idx_d    = word_idx_q;
        beat_d        = beat_q;
        word_d        = word_q;
        frame_error_d = frame_error_q;
        case (state_q)
            S_IDLE: begin
                if (ddr_read_start && ddr_read_start_valid) begin
                    base_d        = odd_even_flag ? BUF1_BASE : BUF0_BASE;
                    flag_d        = odd_even_flag;
                    frame_error_d = 1'b0;
                    pkt_idx_d     = '0;
                    burst_cnt_d   = '0;
                    word_idx_d    = '0;
                    state_d       = S_HDR;
                end
            end
            S_HDR: begin
                if (!pkt_out_alf) begin
                    state_d = S_AR;
                end
            end
            S_AR: begin
                if (M_AXI_ARREADY) begin
                    beat_d  = '0;
                    word_d  = '0;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                if (M_AXI_RVALID) begin
                    if (beat_q < 5'd16) begin
                        word_d[{beat_q[3:0], 5'b0} +: 32] = M_AXI_RDATA;
                        beat_d = beat_q + 5'd1;
                    end
                    if (M_AXI_RRESP != 2'b00) begin
                        frame_error_d = 1'b1;
                    end
                    if (M_AXI_RLAST) begin
                        if (beat_q != 5'd15) begin
                            frame_error_d = 1'b1;
                        end
                        state_d = S_WORD;
                    end else if (beat_q >= 5'd15) begin
                        frame_error_d = 1'b1;
                    end
                end
            end
            S_WORD: begin
                if (!pkt_out_alf) begin
                    burst_cnt_d = burst_cnt_q + 14'd1;
                    if (burst_cnt_q == LAST_BURST) begin
                        state_d = S_FIN;
                    end else if (last_word) begin
                        pkt_idx_d  = pkt_idx_q + 16'd1;
                        word_idx_d = '0;
                        state_d    = S_HDR;
                    end else begin
                        word_idx_d = word_idx_q + 16'd1;
                        state_d    = S_AR;
                    end
                end
            end
            S_FIN: begin
                if (ddr_read_finish_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: packet strobes honour alf in the same cycle.
    always_comb begin
        ddr_read_start_ready  = (state_q == S_IDLE);
        ddr_read_finish       = (state_q == S_FIN);
        ddr_read_finish_valid = (state_q == S_FIN);
        frame_error           = frame_error_q;
        pkt_out_en            = 1'b0;
        pkt_out_data          = '0;
        pkt_out_md_en         = 1'b0;
        pkt_out_md            = '0;
        M_AXI_ARVALID         = (state_q == S_AR);
        M_AXI_ARADDR          = '0;
        M_AXI_RREADY          = (state_q == S_RD);
        if (state_q == S_AR) begin
            M_AXI_ARADDR = base_q + {12'b0, burst_cnt_q, 6'b0};
        end
        if (state_q == S_HDR && !pkt_out_alf) begin
            pkt_out_en   = 1'b1;
            pkt_out_data = {2'b10, 6'b0, DST_MAC, SRC_MAC, ETH_TYPE, pkt_idx_q, 384'b0};
        end
        if (state_q == S_WORD && !pkt_out_alf) begin
            pkt_out_en   = 1'b1;
            pkt_out_data = {(last_word ? 2'b01 : 2'b00), 6'b0, word_q};
            if (last_word) begin
                pkt_out_md_en = 1'b1;
                pkt_out_md    = {pkt_idx_q, PKT_LEN, 223'b0, flag_q};
            end
        end
    end

    assign M_AXI_ARID    = 1'b0;
    assign M_AXI_ARLEN   = 8'd15;
    assign M_AXI_ARSIZE  = 3'b010;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'b0011;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARQOS   = 4'b0000;
    assign M_AXI_ARUSER  = 1'b1;

endmodule

// File: tb/tb_ddr_frame_reader.sv
// tb_ddr_frame_reader
// Drives whole frames through a small AXI read slave and compares the packet
// stream, read addresses and status against a frame model built from the
// buffer base, burst count and packet length.
module tb_ddr_frame_reader;

    localparam int          NB   = 32;
    localparam int          NPKT = NB / 16;
    localparam logic [31:0] B0   = 32'h2BC0_0000;
    localparam logic [31:0] B1   = 32'h2BE0_0000;
    localparam logic [47:0] DMAC = 48'hADAD_ADAD_ADAD;
    localparam logic [47:0] SMAC = 48'hACAC_ACAC_ACAC;
    localparam logic [15:0] ETYP = 16'h9000;

    typedef struct {
        logic flag;
        int   alf_mode;
        int   ar_delay;
        int   gap_pct;
        int   err_burst;
        int   err_beat;
        int   short_burst;
        int   short_last;
        logic exp_err;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         aresetn;
    logic         ddr_read_start, ddr_read_start_valid, ddr_read_start_ready;
    logic         odd_even_flag;
    logic         ddr_read_finish, ddr_read_finish_valid, ddr_read_finish_ready;
    logic         frame_error;
    logic [519:0] pkt_out_data;
    logic         pkt_out_en;
    logic [255:0] pkt_out_md;
    logic         pkt_out_md_en;
    logic         pkt_out_alf;
    logic         M_AXI_ARID;
    logic [31:0]  M_AXI_ARADDR;
    logic [7:0]   M_AXI_ARLEN;
    logic [2:0]   M_AXI_ARSIZE;
    logic [1:0]   M_AXI_ARBURST;
    logic         M_AXI_ARLOCK;
    logic [3:0]   M_AXI_ARCACHE;
    logic [2:0]   M_AXI_ARPROT;
    logic [3:0]   M_AXI_ARQOS;
    logic         M_AXI_ARUSER;
    logic         M_AXI_ARVALID, M_AXI_ARREADY;
    logic         M_AXI_RID;
    logic [31:0]  M_AXI_RDATA;
    logic [1:0]   M_AXI_RRESP;
    logic         M_AXI_RLAST, M_AXI_RUSER, M_AXI_RVALID, M_AXI_RREADY;

    ddr_frame_reader #(.FRAME_BURSTS(NB)) dut (
        .clk(clk), .aresetn(aresetn),
        .ddr_read_start(ddr_read_start), .ddr_read_start_valid(ddr_read_start_valid),
        .ddr_read_start_ready(ddr_read_start_ready), .odd_even_flag(odd_even_flag),
        .ddr_read_finish(ddr_read_finish), .ddr_read_finish_valid(ddr_read_finish_valid),
        .ddr_read_finish_ready(ddr_read_finish_ready), .frame_error(frame_error),
        .pkt_out_data(pkt_out_data), .pkt_out_en(pkt_out_en), .pkt_out_md(pkt_out_md),
        .pkt_out_md_en(pkt_out_md_en), .pkt_out_alf(pkt_out_alf),
        .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
        .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARLOCK(M_AXI_ARLOCK),
        .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARQOS(M_AXI_ARQOS),
        .M_AXI_ARUSER(M_AXI_ARUSER), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RUSER(M_AXI_RUSER), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY)
    );

    int n_vec = 0;
    int n_miss = 0;

    logic [519:0] exp_q[$];
    logic [255:0] exp_md[$];
    logic [31:0]  exp_ar[$];

    int ar_delay = 0, gap_pct = 0, err_burst = -1, err_beat = 0;
    int short_burst = -1, short_last = 15, served = 0;
    int alf_mode = 0, words_seen = 0, hold_left = 0;
    bit hold_done = 0, slave_busy = 0;

    // One comparison: counts it, reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [519:0] act, input logic [519:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected frame: header per packet, one word per burst whose lanes hold the beat byte addresses.
    task automatic buildModel(input logic [31:0] base, input logic flag, input int sb, input int sl);
        logic [511:0] wd;
        logic [31:0]  addr;
        int           b;
        exp_q.delete();
        exp_md.delete();
        exp_ar.delete();
        for (int p = 0; p < NPKT; p++) begin
            exp_q.push_back({2'b10, 6'b0, DMAC, SMAC, ETYP, 16'(p), 384'b0});
            for (int w = 0; w < 16; w++) begin
                b    = p * 16 + w;
                addr = base + 32'(b * 64);
                exp_ar.push_back(addr);
                wd = '0;
                for (int k = 0; k < 16; k++) begin
                    if (b != sb || k <= sl) wd[k*32 +: 32] = addr + 32'(k * 4);
                end
                exp_q.push_back({((w == 15) ? 2'b01 : 2'b00), 6'b0, wd});
            end
            exp_md.push_back({16'(p), 16'd17, 223'b0, flag});
        end
    endtask

    // AXI read slave: returns beat byte address as data, with optional delays, gaps and faults.
    initial begin
        logic        ar_hs_s, r_hs_s, prev_wait;
        logic [31:0] ar_addr_s, prev_addr, baddr;
        int          beat, cur_burst, ar_cnt, last_b;
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
        M_AXI_RLAST = 0; M_AXI_RID = 0; M_AXI_RUSER = 0;
        beat = 0; cur_burst = 0; ar_cnt = 0; last_b = 15; prev_wait = 0; prev_addr = 0; baddr = 0;
        forever begin
            @(negedge clk);
            ar_hs_s   = aresetn && M_AXI_ARVALID && M_AXI_ARREADY;
            r_hs_s    = aresetn && M_AXI_RVALID && M_AXI_RREADY;
            ar_addr_s = M_AXI_ARADDR;
            if (aresetn && prev_wait)
                checkOutput("araddr_stable", {M_AXI_ARVALID, M_AXI_ARADDR}, {1'b1, prev_addr});
            prev_wait = aresetn && M_AXI_ARVALID && !M_AXI_ARREADY;
            prev_addr = M_AXI_ARADDR;
            if (ar_hs_s) begin
                checkOutput("ar_pending", exp_ar.size() > 0, 1);
                if (exp_ar.size() > 0) checkOutput("araddr", ar_addr_s, exp_ar.pop_front());
            end
            @(posedge clk); #1;
            if (!aresetn) begin
                slave_busy = 0; M_AXI_RVALID = 0; M_AXI_ARREADY = 0;
                M_AXI_RLAST = 0; M_AXI_RRESP = 0; ar_cnt = 0;
            end else begin
                if (r_hs_s) begin
                    if (beat == last_b) slave_busy = 0;
                    beat++;
                end
                if (ar_hs_s) begin
                    slave_busy = 1; beat = 0; baddr = ar_addr_s;
                    cur_burst = served; served++; ar_cnt = 0;
                    last_b = (cur_burst == short_burst) ? short_last : 15;
                end else if (M_AXI_ARVALID) begin
                    ar_cnt++;
                end
                M_AXI_ARREADY = !slave_busy && (ar_cnt >= ar_delay);
                if (slave_busy) begin
                    if (!M_AXI_RVALID || r_hs_s) M_AXI_RVALID = int'($urandom_range(0, 99)) >= gap_pct;
                    M_AXI_RDATA = baddr + 32'(beat * 4);
                    M_AXI_RRESP = (cur_burst == err_burst && beat == err_beat) ? 2'b10 : 2'b00;
                    M_AXI_RLAST = (beat == last_b);
                end else begin
                    M_AXI_RVALID = 0; M_AXI_RLAST = 0; M_AXI_RRESP = 0;
                end
            end
        end
    end

    // Packet monitor: every emitted word must be the next one the frame model predicts.
    initial begin
        logic [519:0] w;
        forever begin
            @(negedge clk);
            if (aresetn) begin
                if (pkt_out_alf) checkOutput("alf_blocks_en", pkt_out_en, 0);
                if (pkt_out_md_en && !pkt_out_en) checkOutput("md_without_en", pkt_out_en, 1);
                if (pkt_out_en) begin
                    words_seen++;
                    checkOutput("word_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        w = exp_q.pop_front();
                        checkOutput("pkt_word", pkt_out_data, w);
                        checkOutput("md_en", pkt_out_md_en, w[519:518] == 2'b01);
                        if (w[519:518] == 2'b01 && exp_md.size() > 0)
                            checkOutput("pkt_md", pkt_out_md, exp_md.pop_front());
                    end
                end
            end
        end
    end

    // Almost-full driver: off, random, or a single 50-cycle hold once the packet is under way.
    initial begin
        pkt_out_alf = 0;
        forever begin
            @(posedge clk); #1;
            case (alf_mode)
                1: pkt_out_alf = ($urandom_range(0, 3) == 0);
                2: begin
                    if (hold_left > 0) begin
                        pkt_out_alf = 1; hold_left--;
                    end else if (!hold_done && words_seen >= 5) begin
                        pkt_out_alf = 1; hold_left = 49; hold_done = 1;
                    end else begin
                        pkt_out_alf = 0;
                    end
                end
                default: pkt_out_alf = 0;
            endcase
        end
    end

    // Run-away guard.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic setupFrame(input vec_t v);
        buildModel(v.flag ? B1 : B0, v.flag, v.short_burst, v.short_last);
        ar_delay = v.ar_delay; gap_pct = v.gap_pct;
        err_burst = v.err_burst; err_beat = v.err_beat;
        short_burst = v.short_burst; short_last = v.short_last;
        served = 0; words_seen = 0; hold_left = 0; hold_done = 0;
        alf_mode = v.alf_mode;
    endtask

    task automatic startFrame(input logic flag);
        @(posedge clk); #1;
        ddr_read_start = 1; ddr_read_start_valid = 1; odd_even_flag = flag;
        @(negedge clk);
        checkOutput("start_ready_idle", ddr_read_start_ready, 1);
        @(posedge clk); #1;
        ddr_read_start = 0; ddr_read_start_valid = 0; odd_even_flag = ~flag;
        @(negedge clk);
        checkOutput("frame_error_cleared", frame_error, 0);
    endtask

    task automatic pulseReset();
        @(posedge clk); #1;
        aresetn = 0;
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1;
        exp_q.delete(); exp_md.delete(); exp_ar.delete();
    endtask

    // Full frame: start, poke ignored starts while busy, wait for finish, then finish handshake.
    task automatic applyStimulus(input vec_t v);
        bit poke;
        bit done;
        setupFrame(v);
        startFrame(v.flag);
        done = 0;
        for (int c = 0; c < 20000 && !done; c++) begin
            @(posedge clk); #1;
            poke = ($urandom_range(0, 15) == 0);
            ddr_read_start = poke; ddr_read_start_valid = poke;
            @(negedge clk);
            if (poke) checkOutput("start_ignored_busy", ddr_read_start_ready, 0);
            if (ddr_read_finish_valid) done = 1;
            ddr_read_start = 0; ddr_read_start_valid = 0;
        end
        checkOutput("finish_seen", done, 1);
        alf_mode = 0;
        if (!done) begin
            pulseReset();
            return;
        end
        checkOutput("finish_flag", ddr_read_finish, 1);
        checkOutput("frame_error", frame_error, v.exp_err);
        checkOutput("words_left", exp_q.size(), 0);
        checkOutput("ar_left", exp_ar.size(), 0);
        checkOutput("md_left", exp_md.size(), 0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("finish_held", ddr_read_finish_valid, 1);
        end
        @(posedge clk); #1;
        ddr_read_finish_ready = 1;
        @(posedge clk); #1;
        ddr_read_finish_ready = 0;
        @(negedge clk);
        checkOutput("finish_dropped", {ddr_read_finish, ddr_read_finish_valid}, 0);
        checkOutput("ready_after_fin", ddr_read_start_ready, 1);
        checkOutput("frame_error_sticky", frame_error, v.exp_err);
    endtask

    // Reset pulse while a burst is being read: everything must fall back to reset values.
    task automatic resetMidRead();
        vec_t v;
        bit   reached;
        v = '{1'b1, 0, 0, 20, 1, 0, -1, 15, 1'b1};
        setupFrame(v);
        startFrame(v.flag);
        reached = 0;
        for (int c = 0; c < 5000 && !reached; c++) begin
            @(negedge clk);
            if (served >= 3 && M_AXI_RREADY) reached = 1;
        end
        checkOutput("rd_reached", reached, 1);
        checkOutput("error_before_reset", frame_error, 1);
        @(posedge clk); #1;
        aresetn = 0;
        @(negedge clk);
        checkOutput("rst_start_ready", ddr_read_start_ready, 1);
        checkOutput("rst_arvalid", M_AXI_ARVALID, 0);
        checkOutput("rst_rready", M_AXI_RREADY, 0);
        checkOutput("rst_pkt_en", {pkt_out_en, pkt_out_md_en}, 0);
        checkOutput("rst_finish", {ddr_read_finish, ddr_read_finish_valid}, 0);
        checkOutput("rst_frame_error", frame_error, 0);
        @(posedge clk); #1;
        aresetn = 1;
        exp_q.delete(); exp_md.delete(); exp_ar.delete();
    endtask

    initial begin
        vec_t tbl[6];
        vec_t rv;
        tbl[0] = '{1'b1, 0, 0,  0, -1, 0, -1, 15, 1'b0};
        tbl[1] = '{1'b0, 2, 0,  0, -1, 0, -1, 15, 1'b0};
        tbl[2] = '{1'b1, 0, 0,  0,  5, 3, -1, 15, 1'b1};
        tbl[3] = '{1'b0, 0, 1, 10, -1, 0, -1, 15, 1'b0};
        tbl[4] = '{1'b1, 0, 10, 50, -1, 0, -1, 15, 1'b0};
        tbl[5] = '{1'b0, 1, 2, 20, -1, 0, 20,  7, 1'b1};

        aresetn = 0;
        ddr_read_start = 0; ddr_read_start_valid = 0; odd_even_flag = 0;
        ddr_read_finish_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_start_ready", ddr_read_start_ready, 1);
        checkOutput("reset_arvalid", M_AXI_ARVALID, 0);
        checkOutput("reset_pkt_en", pkt_out_en, 0);
        checkOutput("reset_finish_valid", ddr_read_finish_valid, 0);
        checkOutput("reset_frame_error", frame_error, 0);
        @(posedge clk); #1;
        aresetn = 1;

        for (int i = 0; i < 6; i++) begin
            $display("[TB] table row %0d", i);
            applyStimulus(tbl[i]);
        end

        $display("[TB] reset during read");
        resetMidRead();
        applyStimulus(tbl[3]);

        for (int i = 0; i < 4; i++) begin
            rv.flag = 1'($urandom_range(0, 1));
            rv.alf_mode = 1;
            rv.ar_delay = $urandom_range(0, 4);
            rv.gap_pct = $urandom_range(0, 40);
            rv.short_burst = -1;
            rv.short_last = 15;
            if ($urandom_range(0, 1) == 1) begin
                rv.err_burst = $urandom_range(0, NB - 1);
                rv.err_beat = $urandom_range(0, 15);
                rv.exp_err = 1'b1;
            end else begin
                rv.err_burst = -1;
                rv.err_beat = 0;
                rv.exp_err = 1'b0;
            end
            $display("[TB] random frame %0d flag=%0d err_burst=%0d", i, rv.flag, rv.err_burst);
            applyStimulus(rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
